// File: rtl/refcpu_fetch_unit_pkg.sv
// Shared definitions for the reference CPU fetch unit: bus types, fetch FSM
// state encoding and the NOP word returned for rejected fetches.
package refcpu_fetch_unit_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_ADDR,
    F_DATA,
    F_HOLD,
    F_DRAIN
  } fetch_state_t;

  localparam word_t FETCH_NOP = 32'h0;

  // The instruction bus only ever sees word-aligned addresses.
  function automatic addr_t fetch_bus_addr(input addr_t pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/refcpu_fetch_unit.sv
// Multi-cycle instruction fetch unit: one request at a time, two-phase ibus
// transaction, valid/ready hand-off to decode, flush with stale-response drain.
// Optional misaligned-PC trap enabled by defining REFCPU_FETCH_ALIGN_CHECK_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// F_IDLE  | ready for a new fetch request
// F_ADDR  | address phase on ibus, waiting for ibus_addr_ok
// F_DATA  | address accepted, waiting for ibus_data_ok
// F_HOLD  | instruction presented to decode, waiting for inst_ready
// F_DRAIN | fetch flushed, swallowing the outstanding bus response
module refcpu_fetch_unit
  import refcpu_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  input  logic        flush,
  output logic        ibus_valid,
  output logic [31:0] ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_addr_err
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q;
  addr_t        addr_q;
  word_t        data_q;
  logic         flush_pend_q, flush_pend_d;
  logic         accept;
  logic         misaligned;
  logic         capture;

  assign accept = (state_q == F_IDLE) && req_valid && !flush;

`ifdef REFCPU_FETCH_ALIGN_CHECK_EN
  assign misaligned = (req_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    capture      = 1'b0;
    unique case (state_q)
      F_IDLE: begin
        flush_pend_d = 1'b0;
        if (accept) begin
          state_d = misaligned ? F_HOLD : F_ADDR;
        end
      end
      F_ADDR: begin
        // The address phase cannot be withdrawn, so a flush here is parked
        // until the bus takes the address.
        if (ibus_addr_ok) begin
          flush_pend_d = 1'b0;
          if (flush_pend_q || flush) begin
            state_d = ibus_data_ok ? F_IDLE : F_DRAIN;
          end else if (ibus_data_ok) begin
            capture = 1'b1;
            state_d = F_HOLD;
          end else begin
            state_d = F_DATA;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      F_DATA: begin
        if (flush) begin
          state_d = ibus_data_ok ? F_IDLE : F_DRAIN;
        end else if (ibus_data_ok) begin
          capture = 1'b1;
          state_d = F_HOLD;
        end
      end
      F_HOLD: begin
        if (flush || inst_ready) begin
          state_d = F_IDLE;
        end
      end
      F_DRAIN: begin
        if (ibus_data_ok) begin
          state_d = F_IDLE;
        end
      end
      default: begin
        state_d = F_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= F_IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= '0;
      addr_q <= '0;
    end else if (accept) begin
      pc_q <= req_pc;
      if (!misaligned) begin
        addr_q <= fetch_bus_addr(req_pc);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= FETCH_NOP;
    end else if (capture) begin
      data_q <= ibus_data;
    end else if (accept && misaligned) begin
      data_q <= FETCH_NOP;
    end
  end

`ifdef REFCPU_FETCH_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end

  assign inst_addr_err = err_q;
`else
  assign inst_addr_err = 1'b0;
`endif

  assign req_ready  = (state_q == F_IDLE) && !flush;
  assign ibus_valid = (state_q == F_ADDR);
  assign ibus_addr  = addr_q;
  assign inst_valid = (state_q == F_HOLD);
  assign inst       = data_q;
  assign inst_pc    = pc_q;

endmodule

// File: tb/tb_refcpu_fetch_unit.sv
// Scoreboard bench for refcpu_fetch_unit: a bus responder with configurable
// delays, a request driver that predicts delivered instructions, and a monitor.
module tb_refcpu_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        ibus_valid;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok = 1'b0;
  logic        ibus_data_ok = 1'b0;
  logic [31:0] ibus_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_addr_err;

  refcpu_fetch_unit dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .flush(flush),
    .ibus_valid(ibus_valid), .ibus_addr(ibus_addr),
    .ibus_addr_ok(ibus_addr_ok), .ibus_data_ok(ibus_data_ok), .ibus_data(ibus_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_addr_err(inst_addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

`ifdef REFCPU_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  // bench configuration shared by the processes
  int          cfg_a = -1;
  int          cfg_d = -1;
  int          stray_pct = 10;
  int          rdy_pct = 100;
  int          rdy_hold = 0;
  logic [31:0] bus_word = '0;
  logic [31:0] exp_addr = '0;
  bit          no_bus = 1'b0;
  int          first_valid_cyc = 0;
  int          hs_cyc = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // instruction bus responder
  int          acnt = -1;
  int          dleft = 0;
  bit          pending = 1'b0;
  bit          addr_wait = 1'b0;
  logic [31:0] word_lat = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ibus_addr_ok = 1'b0;
      ibus_data_ok = 1'b0;
      ibus_data    = $urandom;
      if (!resetn) begin
        pending = 1'b0; addr_wait = 1'b0; acnt = -1;
      end else if (pending) begin
        if (ibus_valid) begin
          tests++; fails++;
          $display("FAIL one_outstanding: got ibus_valid=1, expected 0 (cycle %0d)", cyc);
        end
        dleft--;
        if (dleft == 0) begin
          ibus_data_ok = 1'b1;
          ibus_data    = word_lat;
          pending      = 1'b0;
        end
      end else if (ibus_valid) begin
        chk("bus_access_allowed", {31'd0, no_bus}, 32'd0);
        chk("ibus_addr", ibus_addr, exp_addr);
        if (acnt < 0) acnt = (cfg_a < 0) ? int'($urandom_range(0, 3)) : cfg_a;
        if (acnt == 0) begin
          int d;
          ibus_addr_ok = 1'b1;
          addr_wait    = 1'b0;
          acnt         = -1;
          word_lat     = bus_word;
          d = (cfg_d < 0) ? int'($urandom_range(0, 3)) : cfg_d;
          if (d == 0) begin
            ibus_data_ok = 1'b1;
            ibus_data    = word_lat;
          end else begin
            pending = 1'b1;
            dleft   = d;
          end
        end else begin
          acnt--;
          addr_wait = 1'b1;
        end
      end else begin
        if (addr_wait) begin
          tests++; fails++;
          $display("FAIL ibus_valid_held: got 0 before addr_ok, expected 1 (cycle %0d)", cyc);
          addr_wait = 1'b0;
          acnt = -1;
        end
        if ($urandom_range(0, 99) < stray_pct) ibus_data_ok = 1'b1;
      end
    end
  end

  // decode-side ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (inst_valid && rdy_hold > 0) begin
        inst_ready = 1'b0;
        rdy_hold--;
      end else begin
        inst_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // monitor: pops the scoreboard on every counted instruction handshake
  bit          prev_valid = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_pc = '0;
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_valid = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (inst_valid) begin
          chk("req_ready_while_holding", {31'd0, req_ready}, 32'd0);
          if (!prev_valid) first_valid_cyc = cyc;
          if (prev_hold) begin
            chk("inst_stable", inst, prev_inst);
            chk("inst_pc_stable", inst_pc, prev_pc);
          end
          if (inst_ready && !flush) begin
            if (sb.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_inst: got inst=%h pc=%h, expected none (cycle %0d)",
                       inst, inst_pc, cyc);
            end else begin
              mon_e = sb.pop_front();
              chk("inst", inst, mon_e.word);
              chk("inst_pc", inst_pc, mon_e.pc);
              chk("inst_addr_err", {31'd0, inst_addr_err}, {31'd0, mon_e.err});
            end
            hs_cyc = cyc;
          end
        end
        prev_valid = inst_valid;
        prev_hold  = inst_valid && !inst_ready && !flush;
        prev_inst  = inst;
        prev_pc    = inst_pc;
      end
    end
  end

  // One fetch. flush_off: cycle (counted from the first cycle after acceptance)
  // at which flush is pulsed, -1 for none. exp_lat: cycles from acceptance to
  // inst_valid, -1 to skip that check.
  task automatic do_txn(input logic [31:0] pc, input logic [31:0] word,
                        input int flush_off, input int exp_lat);
    int   k;
    int   acc;
    bit   cancelled;
    bit   done;
    bit   mis;
    exp_t e;
    mis  = ALIGN_CHECK && (pc[1:0] != 2'b00);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #2;
      if (req_ready) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got req_ready=0 for 200 cycles, expected 1");
      return;
    end
    e.pc     = pc;
    e.word   = mis ? 32'h0 : word;
    e.err    = mis;
    bus_word = word;
    exp_addr = {pc[31:2], 2'b00};
    no_bus   = mis;
    req_pc    = pc;
    req_valid = 1'b1;
    sb.push_back(e);
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_pc    = $urandom;
    cancelled = 1'b0;
    done      = 1'b0;
    k         = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (req_ready) begin
        done = 1'b1;
      end else begin
        if (k == flush_off) begin
          flush = 1'b1;
          cancelled = 1'b1;
          sb.delete();
        end
        k++;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL txn_timeout: got no return to idle in 200 cycles, expected completion");
      sb.delete();
    end else if (!cancelled) begin
      chk("idle_after_handshake", cyc, hs_cyc + 1);
      if (exp_lat >= 0) chk("latency", first_valid_cyc - acc, exp_lat);
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  // request offered together with flush must not be taken
  task automatic idle_flush();
    @(posedge clk);
    #2;
    req_pc    = $urandom & 32'hFFFF_FFFC;
    req_valid = 1'b1;
    flush     = 1'b1;
    #1;
    chk("req_ready_with_flush", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("no_accept_ibus_valid", {31'd0, ibus_valid}, 32'd0);
    chk("no_accept_inst_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    int          fo;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ibus_valid", {31'd0, ibus_valid}, 32'd0);
    chk("rst_ibus_addr", ibus_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_addr_err", {31'd0, inst_addr_err}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // basic: addr_ok at cycle 1, data_ok at cycle 3, inst_valid at cycle 4
    cfg_a = 0; cfg_d = 2; stray_pct = 0; rdy_pct = 100;
    do_txn(32'hBFC0_0000, 32'h2408_0001, -1, 4);

    // backpressure: five cycles of inst_ready low
    rdy_hold = 5;
    do_txn(32'h0000_1000, 32'h1234_5678, -1, 4);

    // flush in F_ADDR before addr_ok: addr_ok at cycle 4, data_ok at cycle 6
    cfg_a = 3; cfg_d = 2;
    do_txn(32'h0000_0000, 32'hDEAD_BEEF, 1, -1);
    cfg_a = 0; cfg_d = 1;
    do_txn(32'h0000_0004, 32'hA5A5_0004, -1, 3);

    // flush in F_DATA on the same cycle as data_ok
    cfg_a = 0; cfg_d = 2;
    do_txn(32'h0000_0040, 32'h0BAD_0BAD, 2, -1);

    // same-cycle addr_ok + data_ok, with stray data_ok whenever idle
    cfg_a = 0; cfg_d = 0; stray_pct = 100;
    do_txn(32'h0000_0080, 32'h1111_2222, -1, 2);
    do_txn(32'h0000_0084, 32'h3333_4444, -1, 2);
    stray_pct = 0;

    // flush while holding, same cycle as inst_ready
    rdy_hold = 1;
    do_txn(32'h0000_0100, 32'h5555_6666, 2, -1);
    do_txn(32'h0000_0104, 32'h7777_8888, -1, 2);

    // misaligned fetch
    do_txn(32'h0000_0002, 32'h9999_AAAA, -1, ALIGN_CHECK ? 1 : 2);
    rdy_hold = 2;
    do_txn(32'h0000_0203, 32'hCCCC_DDDD, -1, -1);

    idle_flush();

    // randomized traffic
    cfg_a = -1; cfg_d = -1; stray_pct = 10;
    for (int n = 0; n < 300; n++) begin
      pc = $urandom;
      if ($urandom_range(0, 9) != 0) pc[1:0] = 2'b00;
      fo = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 8)) : -1;
      rdy_pct = int'($urandom_range(30, 100));
      if ($urandom_range(0, 3) == 0) rdy_hold = int'($urandom_range(1, 4));
      do_txn(pc, $urandom, fo, -1);
      if ($urandom_range(0, 19) == 0) idle_flush();
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/refcpu_fetch_unit.md
# refcpu_fetch_unit

Multi-cycle instruction fetch unit for the reference CPU, sitting between the core's commit/PC logic and the decode step. Accepts one fetch request (PC) at a time, performs the two-phase instruction-bus transaction (address accept, then data return) and presents the fetched word with its PC to decode over a valid/ready handshake. Supports flush, which cancels an in-flight fetch and silently discards any stale bus response.

## Interface
- No parameters; address/data width is 32 (`addr_t`, `word_t`).
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  core requests a fetch at req_pc
- req_pc  in  32  fetch address
- req_ready  out  1  unit can accept a request this cycle
- flush  in  1  cancel current fetch and drop any held instruction
- ibus_valid  out  1  bus address phase request
- ibus_addr  out  32  bus address
- ibus_addr_ok  in  1  bus accepted address this cycle
- ibus_data_ok  in  1  bus returns data this cycle
- ibus_data  in  32  returned word, valid with ibus_data_ok
- inst_valid  out  1  fetched instruction available
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- inst_addr_err  out  1  misaligned fetch flag (see Configuration)

## Operation
- States: F_IDLE, F_ADDR, F_DATA, F_HOLD, F_DRAIN.
- F_IDLE: req_ready = !flush. req_valid && req_ready latches req_pc → F_ADDR.
- F_ADDR: ibus_valid=1, ibus_addr=latched PC, held stable until ibus_addr_ok. addr_ok && data_ok same cycle → capture data, F_HOLD; addr_ok alone → F_DATA.
- F_DATA: wait ibus_data_ok; capture ibus_data → F_HOLD.
- F_HOLD: inst_valid=1, inst/inst_pc stable until inst_ready; handshake → F_IDLE.
- Flush: F_IDLE ignored. F_ADDR: ibus_valid must not drop before addr_ok; on addr_ok with data_ok → F_IDLE, without → F_DRAIN; before addr_ok, remember flush (sticky) and apply on addr_ok. F_DATA: data_ok same cycle → F_IDLE (data dropped), else F_DRAIN. F_HOLD: instruction dropped → F_IDLE, even if inst_ready same cycle (no handshake counted).
- F_DRAIN: wait ibus_data_ok, discard data → F_IDLE. Further flush ignored.
- ibus_data_ok outside F_ADDR/F_DATA/F_DRAIN is ignored.
- Only one outstanding bus transaction ever.

## Timing
- Reset values: state F_IDLE; req_ready=1, ibus_valid=0, ibus_addr=0, inst_valid=0, inst=0, inst_pc=0, inst_addr_err=0.
- Reset mid-transaction returns immediately to F_IDLE; bus is expected to be reset together.
- Minimum latency: request accepted cycle 0, ibus_valid cycle 1, addr_ok+data_ok cycle 1, inst_valid cycle 2.
- All outputs are registered or derived from state only (no combinational path from ibus_* or inst_ready to outputs), except req_ready which depends on flush.
- Next request accepted earliest the cycle after the inst handshake.

## Configuration
- REFCPU_FETCH_ALIGN_CHECK_EN defined: request with req_pc[1:0]≠0 issues no bus access; goes F_IDLE → F_HOLD directly (one cycle) with inst=0, inst_pc=req_pc, inst_addr_err=1. Flush in F_HOLD drops it as usual.
- Undefined: no check; ibus_addr[1:0] forced to 2'b00, inst_pc keeps the original req_pc, inst_addr_err tied 0.

## Structure
- Shared defs package gains: `fetch_state_t` enum (F_IDLE..F_DRAIN), constant `FETCH_NOP = 32'h0`.
- Single module; no sub-module required. Flush-sticky bit and captured data register are local.

## Test plan
- Basic: req_pc=0xBFC0_0000, addr_ok cycle 1, data_ok cycle 3 with 0x2408_0001 → inst_valid cycle 4, inst=0x2408_0001, inst_pc=0xBFC0_0000.
- Backpressure: inst_ready low 5 cycles → inst/inst_pc stable, req_ready=0 throughout; handshake → F_IDLE next cycle.
- Flush in F_ADDR before addr_ok: ibus_valid held until addr_ok at cycle 4, data_ok cycle 6 with 0xDEAD_BEEF → no inst_valid; new request at 0x4 returns its own data only.
- Flush in F_DATA same cycle as data_ok → F_IDLE next cycle, inst_valid never asserted.
- Same-cycle addr_ok+data_ok → inst_valid exactly one cycle later; stray data_ok in F_IDLE ignored.
- Misaligned req_pc=0x0000_0002: with macro, inst_addr_err=1, inst=0, ibus_valid never asserted; without macro, ibus_addr=0x0000_0000, inst_pc=0x0000_0002.
